xor_stream_decryptor: RTL and testbench
=======================================

// Module: xor_stream_decryptor
// PURPOSE
//   Receive-side counterpart of the 32-bit XOR encryptor. Recovers plaintext from a framed stream
//   of ciphertext words by XOR with a latched key that can optionally be rotated per word.
//   Input and output use valid/ready handshakes; a small output FIFO absorbs sink backpressure.
//   Sits between the link receiver (ciphertext source) and the plaintext consumer.
// PARAMETERS
//   DATA_W      32  word and key width
//   FIFO_DEPTH  4   output FIFO entries (power of 2, >=2)
//   KEY_ROT     0   left-rotate applied to working key after each word (0..DATA_W-1; 0 = static key)
// PORTS
//   clk        in   1       clock
//   rst_n      in   1       reset: asynchronous, active-low
//   key_load   in   1       pulse: latch key_in as base key (honoured in IDLE only)
//   key_in     in   DATA_W  key value
//   start      in   1       pulse: begin frame of len words (honoured in IDLE only)
//   len        in   16      frame length in words, sampled with start
//   in_valid   in   1       ciphertext word valid
//   in_data    in   DATA_W  ciphertext word
//   in_ready   out  1       decryptor accepts word this cycle
//   out_valid  out  1       plaintext word available (FIFO not empty)
//   out_data   out  DATA_W  plaintext word at FIFO head
//   out_ready  in   1       sink accepts head word
//   busy       out  1       state != IDLE
//   done       out  1       one-cycle pulse: frame fully drained
//   word_cnt   out  16      words accepted in current frame
// BEHAVIOUR
//   Reset (async): state=IDLE; base_key=0, work_key=0, remaining=0, word_cnt=0; FIFO emptied.
//     All outputs 0: in_ready, out_valid, out_data, busy, done, word_cnt. This also applies mid-frame.
//   FSM IDLE -> RUN -> DRAIN -> DONE -> IDLE.
//   IDLE: in_ready=0. key_load => base_key<=key_in.
//     If start: word_cnt<=0, work_key<=base_key, remaining<=len.
//       len!=0 -> RUN; len==0 -> DONE.
//     If key_load and start arrive in the same cycle, work_key takes key_in, not the old base_key.
//   RUN: in_ready = !fifo_full, registered, with no combinational path from out_ready.
//     On in_valid&&in_ready: push in_data^work_key; work_key<=rotl(work_key,KEY_ROT);
//     remaining<=remaining-1; word_cnt<=word_cnt+1.
//     Accept with remaining==1 -> DRAIN.
//   DRAIN: in_ready=0. Move to DONE on the edge where the FIFO is empty, or becomes empty through
//     a pop in that cycle.
//   DONE: done=1 for exactly this cycle, then -> IDLE. word_cnt holds until the next start.
//   key_load and start outside IDLE are ignored; there is no error flag.
//   Latency: a word accepted at edge N shows out_valid=1 with its out_data from edge N onward.
//     This gives 1 cycle when the FIFO was empty.
//   FIFO: push and pop in the same cycle are both allowed whenever not full.
//     The pointers wrap modulo FIFO_DEPTH. The occupancy counter is DATA-independent, $clog2(DEPTH)+1 bits.
//   out_data is stable while out_valid && !out_ready.
//   Arithmetic: XOR is bitwise over DATA_W. The rotate is purely a bit permutation with no carry.
//     remaining and word_cnt are 16-bit; len=65535 is legal.
//   With KEY_ROT=0 and len=1, the output equals the inverse of one encryptor transaction under the same key.
// TESTING
//   1 key 0x12345678, start len=1, in 0xCC99E897, out_ready=1 -> out 0xDEADBEEF one cycle later;
//     done pulses once; word_cnt=1.
//   2 KEY_ROT=1, key 0x80000001, len=3, in 0x0 x3 -> out 0x80000001, 0x00000003, 0x00000006.
//   3 FIFO_DEPTH=4, key 0, len=6, out_ready=0 -> in_ready low after 4 accepts.
//     Then out_ready=1 -> all 6 words out in order; done fires only after the 6th pop.
//   4 start len=0 -> DONE next cycle, done=1 for one cycle; no output; in_ready stays 0.
//   5 key_load 0xFFFF0000 during RUN -> ignored for the frame; next frame uses the new key.
//   6 rst_n low after 2 of 5 words -> immediately out_valid=0, busy=0, word_cnt=0.
//     A new frame after release decodes correctly.

Source files
------------

// File: rtl/xor_stream_decryptor.sv
// XOR stream decryptor: framed ciphertext in, plaintext out through a small FIFO.
// The working key is latched at frame start and optionally left-rotated after each word.
module xor_stream_decryptor #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned KEY_ROT    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_load,
  input  logic [DATA_W-1:0] key_in,
  input  logic              start,
  input  logic [15:0]       len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [15:0]       word_cnt
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t              state, state_n;
  logic [DATA_W-1:0]   base_key, base_key_n;
  logic [DATA_W-1:0]   work_key, work_key_n;
  logic [15:0]         remaining, remaining_n;
  logic [15:0]         word_cnt_n;
  logic                in_ready_n, out_valid_n;

  logic [DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    count, count_n;
  logic                push, pop;

  // Left rotate as a pure bit permutation; KEY_ROT = 0 is the identity.
  function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      r[(i + KEY_ROT) % DATA_W] = x[i];
    end
    return r;
  endfunction

  // in_ready is only ever high in RUN, so this is the accept strobe.
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign count_n  = CNT_W'(count + CNT_W'(push) - CNT_W'(pop));
  assign out_data = mem[rd_ptr];

  // Next-state, key/counter updates and next values of registered outputs.
  always_comb begin
    state_n     = state;
    base_key_n  = base_key;
    work_key_n  = work_key;
    remaining_n = remaining;
    word_cnt_n  = word_cnt;
    case (state)
      S_IDLE: begin
        if (key_load) base_key_n = key_in;
        if (start) begin
          word_cnt_n  = '0;
          work_key_n  = key_load ? key_in : base_key;
          remaining_n = len;
          state_n     = (len != 16'd0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (push) begin
          work_key_n  = rotl(work_key);
          remaining_n = remaining - 16'd1;
          word_cnt_n  = word_cnt + 16'd1;
          if (remaining == 16'd1) state_n = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (count_n == '0) state_n = S_DONE;
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    in_ready_n  = (state_n == S_RUN) && (count_n != CNT_W'(FIFO_DEPTH));
    out_valid_n = (count_n != '0);
  end

  // State, key, counter and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      base_key  <= '0;
      work_key  <= '0;
      remaining <= '0;
      word_cnt  <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      base_key  <= base_key_n;
      work_key  <= work_key_n;
      remaining <= remaining_n;
      word_cnt  <= word_cnt_n;
      in_ready  <= in_ready_n;
      out_valid <= out_valid_n;
      busy      <= (state_n != S_IDLE);
      done      <= (state_n == S_DONE);
    end
  end

  // Output FIFO storage and pointers; entries cleared on reset so out_data reads 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data ^ work_key;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_n;
    end
  end

endmodule

// File: tb/tb_xor_stream_decryptor.sv
// Self-checking bench for xor_stream_decryptor (KEY_ROT=1, FIFO_DEPTH=4).
module tb_xor_stream_decryptor;

  localparam int unsigned DW  = 32;
  localparam int unsigned ROT = 1;

  logic          clk, rst_n;
  logic          key_load, start, in_valid, in_ready, out_valid, out_ready, busy, done;
  logic [DW-1:0] key_in, in_data, out_data;
  logic [15:0]   len, word_cnt;

  xor_stream_decryptor #(.DATA_W(DW), .FIFO_DEPTH(4), .KEY_ROT(ROT)) dut (
    .clk(clk), .rst_n(rst_n), .key_load(key_load), .key_in(key_in),
    .start(start), .len(len), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .busy(busy), .done(done), .word_cnt(word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] expq [$];
  logic [DW-1:0] got_q [$];
  logic [DW-1:0] mkey, base_m, first_out, prev_data;
  logic          prev_hold;
  int            pops_f;
  logic          rnd_rdy;

  typedef struct {
    logic [DW-1:0] key;
    logic [15:0]   len;
    logic [DW-1:0] d0;
    logic [DW-1:0] step;
    logic          rnd;
    logic [DW-1:0] exp_first;
  } vec_t;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mrotl(input logic [DW-1:0] x);
    return (x << ROT) | (x >> (DW - ROT));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: push expected plaintext on accept, compare on pop; check hold stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold && out_valid) chk("hold_stable", out_data, prev_data);
      if (in_valid && in_ready) begin
        expq.push_back(in_data ^ mkey);
        mkey = mrotl(mkey);
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) chk("unexpected_pop", out_data, 32'hxxxxxxxx);
        else chk("pop_data", out_data, expq.pop_front());
        if (pops_f == 0) first_out = out_data;
        got_q.push_back(out_data);
        pops_f++;
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
    end
  end

  // Random sink backpressure when enabled.
  always @(posedge clk) begin
    #1;
    if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic do_start(input logic [DW-1:0] k, input logic ld, input logic [15:0] l);
    pops_f    = 0;
    first_out = '0;
    got_q.delete();
    key_load  = ld;
    key_in    = k;
    start     = 1'b1;
    len       = l;
    if (ld) base_m = k;
    mkey = base_m;
    tick();
    key_load = 1'b0;
    start    = 1'b0;
  endtask

  task automatic feed(input int n, input logic [DW-1:0] d0, input logic [DW-1:0] step,
                      input int pulse_idx);
    int i;
    int cyc;
    i   = 0;
    cyc = 0;
    while (i < n && cyc < 500) begin
      in_valid = 1'b1;
      in_data  = d0 + DW'(i) * step;
      if (i == pulse_idx) begin
        key_load = 1'b1;
        key_in   = 32'hFFFF0000;
      end
      @(negedge clk);
      if (in_ready) i++;
      cyc++;
      tick();
      key_load = 1'b0;
    end
    in_valid = 1'b0;
    if (cyc >= 500) chk("feed_timeout", DW'(i), DW'(n));
  endtask

  task automatic wait_done(input int l);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_seen", DW'(seen), 32'd1);
    chk("word_cnt_at_done", DW'(word_cnt), DW'(l));
    chk("pops_at_done", DW'(pops_f), DW'(l));
    chk("queue_empty", DW'(expq.size()), 32'd0);
    chk("in_ready_at_done", DW'(in_ready), 32'd0);
    @(negedge clk);
    chk("done_one_cycle", DW'(done), 32'd0);
    chk("idle_after_done", DW'(busy), 32'd0);
    chk("word_cnt_holds", DW'(word_cnt), DW'(l));
  endtask

  vec_t vecs [4];

  initial begin
    vecs[0] = '{32'h12345678, 16'd1,  32'hCC99E897, 32'd0, 1'b0, 32'hDEADBEEF};
    vecs[1] = '{32'h80000001, 16'd3,  32'h00000000, 32'd0, 1'b0, 32'h80000001};
    vecs[2] = '{32'hA5A5A5A5, 16'd10, 32'h00000001, 32'd3, 1'b1, 32'hA5A5A5A4};
    vecs[3] = '{32'h00000000, 16'd8,  32'hFFFFFFFF, 32'd0, 1'b1, 32'hFFFFFFFF};

    rst_n = 1'b0; key_load = 1'b0; key_in = '0; start = 1'b0; len = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; rnd_rdy = 1'b0;
    base_m = '0; mkey = '0; prev_hold = 1'b0; pops_f = 0; first_out = '0;
    @(negedge clk);
    chk("rst_in_ready", DW'(in_ready), 32'd0);
    chk("rst_out_valid", DW'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_busy", DW'(busy), 32'd0);
    chk("rst_done", DW'(done), 32'd0);
    chk("rst_word_cnt", DW'(word_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Table-driven frames (key_load and start in the same cycle).
    for (int v = 0; v < 4; v++) begin
      rnd_rdy   = vecs[v].rnd;
      out_ready = 1'b1;
      do_start(vecs[v].key, 1'b1, vecs[v].len);
      feed(int'(vecs[v].len), vecs[v].d0, vecs[v].step, -1);
      wait_done(int'(vecs[v].len));
      rnd_rdy = 1'b0;
      chk("first_out", first_out, vecs[v].exp_first);
      if (v == 1 && got_q.size() == 3) begin
        chk("rot_word1", got_q[1], 32'h00000003);
        chk("rot_word2", got_q[2], 32'h00000006);
      end
      tick();
    end
    out_ready = 1'b1;

    // One-cycle latency into an empty FIFO with the sink stalled.
    out_ready = 1'b0;
    do_start(32'h12345678, 1'b1, 16'd1);
    feed(1, 32'hCC99E897, 32'd0, -1);
    @(negedge clk);
    chk("lat_out_valid", DW'(out_valid), 32'd1);
    chk("lat_out_data", out_data, 32'hDEADBEEF);
    out_ready = 1'b1;
    wait_done(1);
    tick();

    // Backpressure: FIFO fills after 4 accepts, done only after 6th pop.
    out_ready = 1'b0;
    do_start(32'h0, 1'b1, 16'd6);
    feed(4, 32'h100, 32'd1, -1);
    in_valid = 1'b1;
    in_data  = 32'h104;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("full_in_ready_low", DW'(in_ready), 32'd0);
      tick();
    end
    chk("full_no_done", DW'(busy), 32'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    feed(2, 32'h104, 32'd1, -1);
    wait_done(6);
    tick();

    // Zero-length frame: straight to DONE, no output.
    do_start(32'h0, 1'b0, 16'd0);
    @(negedge clk);
    chk("len0_done", DW'(done), 32'd1);
    chk("len0_in_ready", DW'(in_ready), 32'd0);
    chk("len0_out_valid", DW'(out_valid), 32'd0);
    @(negedge clk);
    chk("len0_done_clear", DW'(done), 32'd0);
    chk("len0_idle", DW'(busy), 32'd0);
    tick();

    // key_load during RUN is ignored; next frames use keys loaded in IDLE.
    do_start(32'h11112222, 1'b1, 16'd3);
    feed(3, 32'h33334444, 32'd5, 1);
    wait_done(3);
    chk("runload_first", first_out, 32'h22226666);
    tick();
    do_start(32'hFFFF0000, 1'b1, 16'd2);
    feed(2, 32'h0000FFFF, 32'd0, -1);
    wait_done(2);
    chk("newkey_first", first_out, 32'hFFFFFFFF);
    tick();
    do_start(32'h0, 1'b0, 16'd1);
    feed(1, 32'h0000FFFF, 32'd0, -1);
    wait_done(1);
    chk("basekey_kept", first_out, 32'hFFFFFFFF);
    tick();

    // Asynchronous reset mid-frame, then a clean frame.
    out_ready = 1'b0;
    do_start(32'h0BADF00D, 1'b1, 16'd5);
    feed(2, 32'h1234, 32'd7, -1);
    @(negedge clk);
    chk("pre_rst_word_cnt", DW'(word_cnt), 32'd2);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", DW'(out_valid), 32'd0);
    chk("mid_rst_busy", DW'(busy), 32'd0);
    chk("mid_rst_word_cnt", DW'(word_cnt), 32'd0);
    chk("mid_rst_in_ready", DW'(in_ready), 32'd0);
    expq.delete();
    base_m = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    do_start(32'h5A5A0F0F, 1'b1, 16'd4);
    feed(4, 32'hDEAD0000, 32'h11, -1);
    wait_done(4);
    chk("post_rst_first", first_out, 32'h84F70F0F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
